// File: rtl/out_buff_ctrl_mc.sv
// Multi-channel output-buffer controller.
// Keeps NUM_CH ring buffers of DEPTH entries (pointers and occupancy only; the
// RAM is external) and arbitrates their shared read port round-robin.
// A downstream Nack holds the current grant without consuming anything.
module out_buff_ctrl_mc #(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 5,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int LOG_DEPTH = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int LOG_CH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Active,
  input  logic [NUM_CH-1:0]             I_Clr,
  input  logic [NUM_CH-1:0]             I_We,
  input  logic                          I_Re,
  input  logic                          I_Nack,
  output logic [NUM_CH*LOG_DEPTH-1:0]   O_WPtr,
  output logic [LOG_DEPTH-1:0]          O_RPtr,
  output logic [LOG_CH-1:0]             O_RCh,
  output logic                          O_RValid,
  output logic [NUM_CH*CNT_W-1:0]       O_Count,
  output logic [NUM_CH-1:0]             O_Full,
  output logic [NUM_CH-1:0]             O_Empty,
  output logic [NUM_CH-1:0]             O_AFull,
  output logic [NUM_CH-1:0]             O_Ready,
  output logic [NUM_CH-1:0]             O_Ovf
);

  logic [LOG_DEPTH-1:0] wptr_q [NUM_CH];
  logic [LOG_DEPTH-1:0] wptr_d [NUM_CH];
  logic [LOG_DEPTH-1:0] rptr_q [NUM_CH];
  logic [LOG_DEPTH-1:0] rptr_d [NUM_CH];
  logic [CNT_W-1:0]     cnt_q  [NUM_CH];
  logic [CNT_W-1:0]     cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic [LOG_CH-1:0]    rr_q, rr_d;

  logic [LOG_CH-1:0]    grant, cand;
  logic                 any_nz, fire, wr_ok, rd_hit;

  // Ring pointer increment; DEPTH need not be a power of two.
  function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
    if (p == LOG_DEPTH'(DEPTH - 1)) return '0;
    return p + LOG_DEPTH'(1);
  endfunction

  // Channel index increment modulo NUM_CH.
  function automatic logic [LOG_CH-1:0] ch_inc(input logic [LOG_CH-1:0] c);
    if (c == LOG_CH'(NUM_CH - 1)) return '0;
    return c + LOG_CH'(1);
  endfunction

  // Round-robin search for the first non-empty channel starting at rr.
  always_comb begin
    grant  = rr_q;
    any_nz = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = LOG_CH'((int'(rr_q) + i) % NUM_CH);
      if (!any_nz && cnt_q[cand] != '0) begin
        grant  = cand;
        any_nz = 1'b1;
      end
    end
    O_RValid = I_Active & any_nz;
    O_RCh    = O_RValid ? grant : rr_q;
    O_RPtr   = rptr_q[O_RCh];
    fire     = O_RValid & I_Re & ~I_Nack;
  end

  // Occupancy flags and packed per-channel outputs, all from registered state.
  always_comb begin
    O_WPtr  = '0;
    O_Count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      O_WPtr[c*LOG_DEPTH +: LOG_DEPTH] = wptr_q[c];
      O_Count[c*CNT_W +: CNT_W]        = cnt_q[c];
      O_Full[c]  = (cnt_q[c] == CNT_W'(DEPTH));
      O_Empty[c] = (cnt_q[c] == '0);
      O_AFull[c] = (cnt_q[c] >= CNT_W'(AFULL_TH));
      O_Ready[c] = (~O_Empty[c] & ~O_Full[c]) | (O_Empty[c] & I_Active);
    end
    O_Ovf = ovf_q;
  end

  // Per-channel next state: clear wins over write and read; full drops writes.
  always_comb begin
    wr_ok  = 1'b0;
    rd_hit = 1'b0;
    ovf_d  = ovf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      cnt_d[c]  = cnt_q[c];
      wr_ok     = I_We[c] & ~O_Full[c];
      rd_hit    = fire & (grant == LOG_CH'(c));
      if (I_Clr[c]) begin
        wptr_d[c] = '0;
        rptr_d[c] = '0;
        cnt_d[c]  = '0;
        ovf_d[c]  = 1'b0;
      end else begin
        if (I_We[c] & O_Full[c]) ovf_d[c] = 1'b1;
        if (wr_ok)  wptr_d[c] = ptr_inc(wptr_q[c]);
        if (rd_hit) rptr_d[c] = ptr_inc(rptr_q[c]);
        unique case ({wr_ok, rd_hit})
          2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
          2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
          default: cnt_d[c] = cnt_q[c];
        endcase
      end
    end
    rr_d = rr_q;
    if (fire && !I_Clr[grant]) rr_d = ch_inc(grant);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      ovf_q <= '0;
      rr_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_out_buff_ctrl_mc.sv
// Bench for out_buff_ctrl_mc: directed scenarios plus a random phase, with a
// reference model and a per-channel scoreboard of written slot addresses.
module tb_out_buff_ctrl_mc;

  localparam int NUM_CH    = 4;
  localparam int DEPTH     = 5;
  localparam int AFULL_TH  = DEPTH - 1;
  localparam int LOG_DEPTH = 3;
  localparam int CNT_W     = 3;
  localparam int LOG_CH    = 2;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        I_Active = 1'b0;
  logic [NUM_CH-1:0]           I_Clr = '0;
  logic [NUM_CH-1:0]           I_We = '0;
  logic                        I_Re = 1'b0;
  logic                        I_Nack = 1'b0;
  logic [NUM_CH*LOG_DEPTH-1:0] O_WPtr;
  logic [LOG_DEPTH-1:0]        O_RPtr;
  logic [LOG_CH-1:0]           O_RCh;
  logic                        O_RValid;
  logic [NUM_CH*CNT_W-1:0]     O_Count;
  logic [NUM_CH-1:0]           O_Full, O_Empty, O_AFull, O_Ready, O_Ovf;

  always #5 clock = ~clock;

  out_buff_ctrl_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .I_Active(I_Active), .I_Clr(I_Clr),
    .I_We(I_We), .I_Re(I_Re), .I_Nack(I_Nack), .O_WPtr(O_WPtr),
    .O_RPtr(O_RPtr), .O_RCh(O_RCh), .O_RValid(O_RValid), .O_Count(O_Count),
    .O_Full(O_Full), .O_Empty(O_Empty), .O_AFull(O_AFull), .O_Ready(O_Ready),
    .O_Ovf(O_Ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_wptr [NUM_CH];
  int m_rptr [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_ovf  [NUM_CH];
  int m_rr;
  int sb_q   [NUM_CH][$];

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int m_grant();
    int c;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (m_rr + i) % NUM_CH;
      if (m_cnt[c] != 0) return c;
    end
    return m_rr;
  endfunction

  function automatic bit m_any();
    for (int i = 0; i < NUM_CH; i++)
      if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear_all();
    for (int c = 0; c < NUM_CH; c++) begin
      m_wptr[c] = 0; m_rptr[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0;
      sb_q[c].delete();
    end
    m_rr = 0;
  endtask

  task automatic drive(input logic [NUM_CH-1:0] we, input logic [NUM_CH-1:0] clr,
                       input logic re, input logic nack, input logic act);
    I_We = we; I_Clr = clr; I_Re = re; I_Nack = nack; I_Active = act;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear_all();
  endtask

  // One clock: compare all outputs at the falling edge, pop the scoreboard on
  // a DUT read, push accepted writes, then advance the model to the next edge.
  task automatic tick();
    bit rv, fire, wok, rd;
    int g, sel, ch, expv, cnt;
    @(negedge clock);
    rv  = I_Active && m_any();
    g   = m_grant();
    sel = rv ? g : m_rr;
    chk("rvalid", int'(O_RValid), int'(rv));
    chk("rch", int'(O_RCh), sel);
    chk("rptr", int'(O_RPtr), m_rptr[sel]);
    for (int c = 0; c < NUM_CH; c++) begin
      cnt = m_cnt[c];
      chk($sformatf("wptr%0d", c), int'(O_WPtr[c*LOG_DEPTH +: LOG_DEPTH]), m_wptr[c]);
      chk($sformatf("count%0d", c), int'(O_Count[c*CNT_W +: CNT_W]), cnt);
      chk($sformatf("full%0d", c), int'(O_Full[c]), int'(cnt == DEPTH));
      chk($sformatf("empty%0d", c), int'(O_Empty[c]), int'(cnt == 0));
      chk($sformatf("afull%0d", c), int'(O_AFull[c]), int'(cnt >= AFULL_TH));
      chk($sformatf("ready%0d", c), int'(O_Ready[c]),
          int'((cnt != 0 && cnt != DEPTH) || (cnt == 0 && I_Active)));
      chk($sformatf("ovf%0d", c), int'(O_Ovf[c]), m_ovf[c]);
    end
    ch = int'(O_RCh);
    if (O_RValid && I_Re && !I_Nack && ch < NUM_CH && !I_Clr[ch]) begin
      if (sb_q[ch].size() == 0) chk("sb_underflow", 1, 0);
      else begin
        expv = sb_q[ch].pop_front();
        chk("sb_rptr", int'(O_RPtr), expv);
      end
    end
    fire = rv && I_Re && !I_Nack;
    for (int c = 0; c < NUM_CH; c++) begin
      if (I_Clr[c]) begin
        m_wptr[c] = 0; m_rptr[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0;
        sb_q[c].delete();
      end else begin
        wok = I_We[c] && (m_cnt[c] != DEPTH);
        rd  = fire && (g == c);
        if (I_We[c] && m_cnt[c] == DEPTH) m_ovf[c] = 1;
        if (wok) begin
          sb_q[c].push_back(m_wptr[c]);
          m_wptr[c] = (m_wptr[c] + 1) % DEPTH;
        end
        if (rd) m_rptr[c] = (m_rptr[c] + 1) % DEPTH;
        m_cnt[c] = m_cnt[c] + (wok ? 1 : 0) - (rd ? 1 : 0);
      end
    end
    if (fire && !I_Clr[g]) m_rr = (g + 1) % NUM_CH;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [NUM_CH-1:0] we_r, clr_r;

    // Reset and idle
    do_reset();
    drive('0, '0, 1'b0, 1'b0, 1'b1); #1;
    chk("rst_empty", int'(O_Empty), 15);
    chk("rst_ready_act", int'(O_Ready), 15);
    chk("rst_rvalid", int'(O_RValid), 0);
    chk("rst_count", int'(O_Count), 0);
    chk("rst_rch", int'(O_RCh), 0);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b0); #1;
    chk("rst_ready_idle", int'(O_Ready), 0);
    tick();

    // Fill channel 2, then overflow it
    for (int i = 1; i <= 5; i++) begin
      drive(4'b0100, '0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 3) chk("afull2_at3", int'(O_AFull[2]), 0);
      if (i == 4) chk("afull2_at4", int'(O_AFull[2]), 1);
    end
    chk("full2", int'(O_Full[2]), 1);
    chk("wptr2_wrap", int'(O_WPtr[2*LOG_DEPTH +: LOG_DEPTH]), 0);
    chk("ovf2_before", int'(O_Ovf[2]), 0);
    drive(4'b0100, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ovf2_after", int'(O_Ovf[2]), 1);
    chk("count2_held", int'(O_Count[2*CNT_W +: CNT_W]), 5);

    // One entry each in channels 0, 1, 3, drained in round-robin order
    do_reset();
    drive(4'b1011, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive('0, '0, 1'b1, 1'b0, 1'b1); #1;
    chk("rr_grant0", int'(O_RCh), 0);
    chk("rr_ptr0", int'(O_RPtr), 0);
    tick();
    chk("rr_grant1", int'(O_RCh), 1);
    chk("rr_ptr1", int'(O_RPtr), 0);
    tick();
    chk("rr_grant3", int'(O_RCh), 3);
    chk("rr_ptr3", int'(O_RPtr), 0);
    tick();
    chk("rr_drained", int'(O_RValid), 0);
    tick();

    // Nack holds the grant on channel 1
    do_reset();
    drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive('0, '0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nack_rch", int'(O_RCh), 1);
      chk("nack_rptr", int'(O_RPtr), 0);
      tick();
    end
    drive('0, '0, 1'b1, 1'b0, 1'b1); #1;
    chk("nack_fire_rch", int'(O_RCh), 1);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b1); #1;
    chk("nack_after_rptr", int'(O_RPtr), 1);
    chk("nack_after_cnt1", int'(O_Count[1*CNT_W +: CNT_W]), 1);
    tick();

    // Simultaneous write and read on channel 0, across the wrap point
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(4'b0001, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("wr_rd_rptr4", int'(O_RPtr), 4);
    chk("wr_rd_cnt", int'(O_Count[0 +: CNT_W]), 3);
    tick();
    chk("wr_rd_rptr_wrap", int'(O_RPtr), 0);
    chk("wr_rd_wptr", int'(O_WPtr[0 +: LOG_DEPTH]), 3);
    chk("wr_rd_cnt_wrap", int'(O_Count[0 +: CNT_W]), 3);

    // Clear beats same-cycle write and read; other channels unaffected
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b0001, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(4'b0010, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clr_pre_ovf0", int'(O_Ovf[0]), 1);
    drive(4'b0011, 4'b0001, 1'b1, 1'b0, 1'b1); #1;
    chk("clr_pre_grant", int'(O_RCh), 0);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b0); #1;
    chk("clr_cnt0", int'(O_Count[0 +: CNT_W]), 0);
    chk("clr_wptr0", int'(O_WPtr[0 +: LOG_DEPTH]), 0);
    chk("clr_rptr0", int'(O_RPtr), 0);
    chk("clr_ovf0", int'(O_Ovf[0]), 0);
    chk("clr_empty0", int'(O_Empty[0]), 1);
    chk("clr_cnt1", int'(O_Count[1*CNT_W +: CNT_W]), 2);
    chk("clr_rr", int'(O_RCh), 0);
    tick();

    // Random traffic: heavy writes first, then light writes to drain
    do_reset();
    for (int i = 0; i < 600; i++) begin
      we_r = (i < 300) ? NUM_CH'($urandom & $urandom)
                       : NUM_CH'($urandom & $urandom & $urandom);
      clr_r = ($urandom_range(0, 15) == 0) ? NUM_CH'(1 << $urandom_range(0, NUM_CH-1)) : '0;
      drive(we_r, clr_r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/out_buff_ctrl_mc.md
Name: out_buff_ctrl_mc

Overview:
Multi-channel successor of the datapath output-buffer controller. Manages NUM_CH independent ring buffers of DEPTH entries that share one read port. Provides per-channel write pointers, occupancy counts, full/empty/almost-full/overflow flags and Nack-aware round-robin read arbitration. Sits between the datapath result writers and the single downstream output link; the buffer RAM itself is external and addressed by the pointers.

Parameters:
NUM_CH, 4, number of channels (>=1)
DEPTH, 5, entries per channel (>=2, need not be a power of two)
AFULL_TH, DEPTH-1, occupancy at or above which O_AFull asserts (1..DEPTH)
LOG_DEPTH, $clog2(DEPTH), pointer width (derived)
CNT_W, $clog2(DEPTH+1), count width (derived)
LOG_CH, (NUM_CH>1)?$clog2(NUM_CH):1, channel index width (derived)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
I_Active  in  1  enables reads and the empty-ready term
I_Clr  in  NUM_CH  per-channel synchronous clear
I_We  in  NUM_CH  per-channel write enable
I_Re  in  1  downstream read request
I_Nack  in  1  downstream Nack, same cycle as I_Re; must not be retimed
O_WPtr  out  NUM_CH*LOG_DEPTH  per-channel write (head) pointer, channel c at [c*LOG_DEPTH +: LOG_DEPTH]
O_RPtr  out  LOG_DEPTH  read (tail) pointer of the granted channel
O_RCh  out  LOG_CH  granted channel index
O_RValid  out  1  a granted channel holds data and I_Active=1
O_Count  out  NUM_CH*CNT_W  per-channel occupancy
O_Full  out  NUM_CH  count==DEPTH
O_Empty  out  NUM_CH  count==0
O_AFull  out  NUM_CH  count>=AFULL_TH
O_Ready  out  NUM_CH  (~Empty&~Full) | (Empty&I_Active)
O_Ovf  out  NUM_CH  sticky: write attempted while full

Behaviour:
- Reset (synchronous): all pointers, counts and O_Ovf = 0; round-robin pointer rr = 0. Hence O_Empty = all 1, O_Full = O_AFull = 0, O_RValid = 0, O_RCh = 0, O_RPtr = 0.
- Per-channel state: wptr, rptr, count, ovf registers. Flags are combinational from count. Pointer increment wraps DEPTH-1 -> 0.
- Write, per channel c: accept when I_We[c] & ~O_Full[c]. Then wptr advances and count increments.
- Write while full: dropped, pointers and count unchanged, ovf[c] <= 1. The full decision uses the registered count, so a same-cycle read on c does not rescue the write.
- Writes are accepted regardless of I_Active.
- Arbitration (combinational): grant is the first channel with count != 0, searching upward from rr and wrapping modulo NUM_CH.
  - O_RValid = I_Active & (any count != 0).
  - O_RCh = grant; O_RPtr = rptr[grant].
  - When O_RValid = 0, O_RCh = rr and O_RPtr = rptr[rr].
- Read fire = O_RValid & I_Re & ~I_Nack. On fire: rptr[grant] advances, count[grant] decrements, rr <= (grant+1) mod NUM_CH.
- Nack (I_Re & I_Nack): no pointer, count or rr change. The same channel stays granted next cycle unless cleared.
- Simultaneous accepted write and fire on the same channel: count unchanged, both pointers advance.
- Latency: data written at cycle t is readable (O_RValid / count update) at t+1. There is no write-to-read bypass.
- I_Clr[c]: at the next edge, wptr, rptr, count and ovf of c go to 0. Clear has priority over a same-cycle write or fire on c; a fire on a cleared granted channel is discarded and rr is unchanged. Other channels are unaffected.
- Reset or clear mid-stream: no residual state. O_Empty[c] = 1 the cycle after.
- I_Active = 0: no fire possible and O_RValid = 0. State is held except writes and clears.
- No combinational path from I_We to O_RValid, O_RCh or O_RPtr.

Test Plan:
- Reset, then idle -> O_Empty = 4'b1111, O_Ready = 4'b1111 with I_Active = 1 and 0 with I_Active = 0, O_RValid = 0, all O_Count = 0.
- Fill channel 2 with 5 writes, then a 6th write -> after the 5th write O_Full[2] = 1, O_AFull[2] set from count 4, O_WPtr[2] = 0 (wrapped); after the 6th, O_Ovf[2] = 1 and count stays 5.
- One write each to channels 0, 1 and 3, then I_Re held high -> grants 0, 1, 3 on consecutive cycles, O_RPtr = 0 each time, then O_RValid = 0.
- Channel 1 holding 2 entries, I_Re = 1 and I_Nack = 1 for 3 cycles, then Nack drops -> O_RCh = 1 and O_RPtr = 0 held for 3 cycles; fire on the 4th cycle, after which O_RPtr = 1 and O_Count[1] = 1.
- Channel 0 at count 3 with a same-cycle write and fire -> count stays 3 and both pointers advance. Repeat across the wrap point: rptr goes 4 -> 0.
- I_Clr[0] asserted in the same cycle as a write to 0, a fire on 0 and a write to 1 -> next cycle channel 0 is all zero with O_Ovf[0] = 0, O_Count[1] increments, and rr is unchanged.
